gate_arbiter: RTL and testbench

Shares the single-event-per-cycle update interface of the parking occupancy counter between `N_GATES` physical gates. Each gate raises an entry or exit request. The block selects one gate round-robin and checks the counter's vacancy flags and the opening hours. It then issues exactly one `car_entered`/`car_exited` pulse and drives that gate's barrier open for a fixed time, or denies the request. It sits between the gate sensor front-ends and the occupancy counter.

---
 rtl/parking_pkg.sv | 9 +
 rtl/gate_arbiter_if.sv | 16 +
 rtl/gate_barrier_timer.sv | 15 +
 rtl/gate_arbiter.sv | 81 ++++++++
 tb/tb_gate_arbiter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/parking_pkg.sv
// parking_pkg: shared arbiter FSM states, gate timing defaults and lot capacity constants
package parking_pkg;
  typedef enum logic [1:0] {IDLE, DECIDE, SETTLE} arb_state_t;
  localparam int OPEN_TIME = 8;
  localparam int CLOSE_TIME = 24;
  localparam int OPEN_CYCLES = 16;
  localparam int UNI_CAPACITY = 64;
  localparam int GENERAL_CAPACITY = 192;
endpackage

// File: rtl/gate_arbiter_if.sv
// gate_arbiter_if: gate requests, hour and vacancy flags in; done/deny/open per gate and counter event pulses out
interface gate_arbiter_if #(parameter int N_GATES = 4);
  logic [4:0] hour;
  logic [N_GATES-1:0] req_valid, req_is_exit, req_is_uni;
  logic uni_is_vacated_space, is_vacated_space;
  logic [N_GATES-1:0] req_done, gate_deny, gate_open;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  modport master (
    output hour, req_valid, req_is_exit, req_is_uni, uni_is_vacated_space, is_vacated_space,
    input req_done, gate_deny, gate_open, car_entered, is_uni_car_entered, car_exited, is_uni_car_exited
  );
  modport slave (
    input hour, req_valid, req_is_exit, req_is_uni, uni_is_vacated_space, is_vacated_space,
    output req_done, gate_deny, gate_open, car_entered, is_uni_car_entered, car_exited, is_uni_car_exited
  );
endinterface

// File: rtl/gate_barrier_timer.sv
// gate_barrier_timer: clk, async active-low reset, load reloads an 8-bit down-counter, open is high while it is nonzero
module gate_barrier_timer #(
  parameter int OPEN_CYCLES = parking_pkg::OPEN_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic open
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= load ? 8'(OPEN_CYCLES) : cnt - {7'd0, cnt != 8'd0};
  assign open = cnt != 8'd0;
endmodule

// File: rtl/gate_arbiter.sv
// gate_arbiter: clk, async active-low reset, bus (slave) -- round-robin gate arbitration onto the occupancy counter with barrier timers
module gate_arbiter
  import parking_pkg::*;
#(
  parameter int N_GATES = 4,
  parameter int OPEN_CYCLES = parking_pkg::OPEN_CYCLES,
  parameter int OPEN_TIME = parking_pkg::OPEN_TIME,
  parameter int CLOSE_TIME = parking_pkg::CLOSE_TIME
) (
  input logic clk,
  input logic reset,
  gate_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_GATES);
  localparam logic [5:0] OT = 6'(OPEN_TIME);
  localparam logic [5:0] CT = 6'(CLOSE_TIME);
  arb_state_t state, state_nx;
  logic [PW-1:0] ptr, win, pick;
  logic found, live, w_exit, w_uni, in_hours, accept, resolve;
  logic [N_GATES-1:0] avail, open, load, win_oh, done_nx, deny_nx;
  logic ce_nx, ue_nx, cx_nx, ux_nx;
  function automatic logic [PW:0] rr_pick(input logic [N_GATES-1:0] v, input logic [PW-1:0] p);
    int idx;
    rr_pick = '0;
    for (int k = N_GATES - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % N_GATES;
      if (v[idx]) rr_pick = {1'b1, PW'(idx)};
    end
  endfunction
  assign avail = bus.req_valid & ~open;
  assign {found, pick} = rr_pick(avail, ptr);
  assign live = bus.req_valid[win];
  assign w_exit = bus.req_is_exit[win];
  assign w_uni = bus.req_is_uni[win];
  assign in_hours = {1'b0, bus.hour} >= OT && {1'b0, bus.hour} < CT;
  assign accept = w_exit | (in_hours & (w_uni ? bus.uni_is_vacated_space : bus.is_vacated_space));
  assign resolve = state == DECIDE && live;
  assign win_oh = N_GATES'(1) << win;
  assign bus.gate_open = open;
  always_comb
    state_nx = state == IDLE ? (found ? DECIDE : IDLE) : state == DECIDE ? (live ? SETTLE : IDLE) : IDLE;
  always_comb begin
    done_nx = resolve ? win_oh : '0;
    deny_nx = resolve && !accept ? win_oh : '0;
    load = resolve && accept ? win_oh : '0;
    ce_nx = resolve & accept & ~w_exit;
    ue_nx = ce_nx & w_uni;
    cx_nx = resolve & accept & w_exit;
    ux_nx = cx_nx & w_uni;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      win <= '0;
      bus.req_done <= '0;
      bus.gate_deny <= '0;
      bus.car_entered <= 1'b0;
      bus.is_uni_car_entered <= 1'b0;
      bus.car_exited <= 1'b0;
      bus.is_uni_car_exited <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) win <= pick;
      if (resolve) ptr <= win == PW'(N_GATES - 1) ? '0 : win + PW'(1);
      bus.req_done <= done_nx;
      bus.gate_deny <= deny_nx;
      bus.car_entered <= ce_nx;
      bus.is_uni_car_entered <= ue_nx;
      bus.car_exited <= cx_nx;
      bus.is_uni_car_exited <= ux_nx;
    end
  for (genvar g = 0; g < N_GATES; g++) begin : g_timer
    gate_barrier_timer #(.OPEN_CYCLES(OPEN_CYCLES)) u_timer (
      .clk(clk),
      .reset(reset),
      .load(load[g]),
      .open(open[g])
    );
  end
endmodule

// File: tb/tb_gate_arbiter.sv
// tb_gate_arbiter: directed self-checking bench for gate_arbiter
module tb_gate_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  int n, nent;
  int ord [4];
  int at [4];
  logic [3:0] drop;
  gate_arbiter_if #(.N_GATES(4)) bus();
  gate_arbiter #(.N_GATES(4), .OPEN_CYCLES(16), .OPEN_TIME(8), .CLOSE_TIME(24)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] all_outs;
    return {bus.req_done, bus.gate_deny, bus.gate_open, bus.car_entered,
            bus.is_uni_car_entered, bus.car_exited, bus.is_uni_car_exited};
  endfunction
  task automatic do_req(input int g, input logic ex, input logic uni, input logic acc, input string tag);
    bus.req_is_exit[g] = ex;
    bus.req_is_uni[g] = uni;
    bus.req_valid[g] = 1'b1;
    tick;
    chk({tag, "_e0_done"}, bus.req_done, 0);
    tick;
    chk({tag, "_done"}, bus.req_done, 32'd1 << g);
    chk({tag, "_deny"}, bus.gate_deny, acc ? 0 : 32'd1 << g);
    chk({tag, "_entered"}, bus.car_entered, acc && !ex);
    chk({tag, "_uni_entered"}, bus.is_uni_car_entered, acc && !ex && uni);
    chk({tag, "_exited"}, bus.car_exited, acc && ex);
    chk({tag, "_uni_exited"}, bus.is_uni_car_exited, acc && ex && uni);
    chk({tag, "_open"}, bus.gate_open[g], acc);
    tick;
    chk({tag, "_e2_pulses"}, {bus.req_done, bus.car_entered, bus.car_exited}, 0);
    chk({tag, "_e2_open"}, bus.gate_open[g], acc);
    bus.req_valid[g] = 1'b0;
    tick;
  endtask
  initial begin
    bus.hour = '0;
    bus.req_valid = '0;
    bus.req_is_exit = '0;
    bus.req_is_uni = '0;
    bus.uni_is_vacated_space = 1'b0;
    bus.is_vacated_space = 1'b0;
    repeat (3) tick;
    chk("reset_outs", all_outs(), 0);
    reset = 1'b1;
    tick;
    bus.hour = 5'd9;
    bus.uni_is_vacated_space = 1'b1;
    bus.is_vacated_space = 1'b1;
    bus.req_is_uni[0] = 1'b1;
    bus.req_valid[0] = 1'b1;
    tick;
    chk("t1_e0_entered", bus.car_entered, 0);
    tick;
    chk("t1_entered", bus.car_entered, 1);
    chk("t1_uni_entered", bus.is_uni_car_entered, 1);
    chk("t1_done", bus.req_done, 4'b0001);
    chk("t1_open", bus.gate_open, 4'b0001);
    n = 1;
    tick;
    chk("t1_e2_entered", bus.car_entered, 0);
    chk("t1_e2_done", bus.req_done, 0);
    bus.req_valid[0] = 1'b0;
    repeat (30) begin
      if (bus.gate_open[0]) n++;
      tick;
    end
    chk("t1_open_cycles", n, 16);
    #2 reset = 1'b0;
    tick;
    reset = 1'b1;
    bus.req_is_uni = '0;
    bus.req_valid = 4'hf;
    nent = 0;
    drop = '0;
    for (int c = 0; c < 40; c++) begin
      tick;
      bus.req_valid = bus.req_valid & ~drop;
      drop = bus.req_done;
      if (bus.car_entered) begin
        if (nent < 4) begin
          ord[nent] = $clog2(bus.req_done);
          at[nent] = c;
        end
        nent++;
      end
    end
    chk("t2_entered_count", nent, 4);
    for (int i = 0; i < 4; i++) chk("t2_order", ord[i], i);
    for (int i = 0; i < 3; i++) chk("t2_spacing", at[i+1] - at[i], 3);
    bus.hour = 5'd10;
    bus.is_vacated_space = 1'b0;
    do_req(2, 1'b0, 1'b0, 1'b0, "full_lot");
    bus.is_vacated_space = 1'b1;
    bus.hour = 5'd7;
    do_req(3, 1'b0, 1'b0, 1'b0, "hour7");
    bus.hour = 5'd24;
    do_req(0, 1'b0, 1'b0, 1'b0, "hour24");
    bus.hour = 5'd3;
    do_req(1, 1'b1, 1'b1, 1'b1, "exit_hour3");
    bus.hour = 5'd23;
    do_req(2, 1'b0, 1'b1, 1'b1, "uni_hour23");
    bus.hour = 5'd8;
    do_req(0, 1'b0, 1'b0, 1'b1, "hour8");
    bus.hour = 5'd12;
    bus.uni_is_vacated_space = 1'b0;
    do_req(3, 1'b0, 1'b1, 1'b0, "uni_full");
    bus.uni_is_vacated_space = 1'b1;
    repeat (20) tick;
    bus.hour = 5'd10;
    bus.req_is_exit = '0;
    bus.req_is_uni = '0;
    bus.req_valid[1] = 1'b1;
    tick;
    bus.req_valid[1] = 1'b0;
    tick;
    chk("abort_outs", all_outs(), 0);
    tick;
    chk("abort_idle_outs", all_outs(), 0);
    bus.req_valid = 4'b1001;
    tick;
    tick;
    chk("abort_ptr_kept", bus.req_done, 4'b0001);
    tick;
    bus.req_valid[0] = 1'b0;
    tick;
    tick;
    chk("gate3_served", bus.req_done, 4'b1000);
    chk("gate3_open", bus.gate_open[3], 1);
    tick;
    bus.req_valid[3] = 1'b0;
    tick;
    do_req(1, 1'b0, 1'b0, 1'b1, "pre_reset");
    chk("g3_open_before_reset", bus.gate_open[3], 1);
    #2 reset = 1'b0;
    #1;
    chk("reset_async_outs", all_outs(), 0);
    tick;
    reset = 1'b1;
    bus.req_valid = 4'b0110;
    tick;
    tick;
    chk("restart_first", bus.req_done, 4'b0010);
    tick;
    bus.req_valid[1] = 1'b0;
    tick;
    tick;
    chk("restart_next", bus.req_done, 4'b0100);
    tick;
    bus.req_valid[2] = 1'b0;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
